// File: rtl/apb_spi_master_fifo.sv
// APB-to-SPI master with TX/RX FIFOs; one START sends every queued word under a single slave select.
// Build option APB_SPI_LOOPBACK_EN adds CMD[2] loopback (MOSI fed back into the receiver, slave selects held high).
module apb_spi_master_fifo #(
    parameter int DATA_W     = 8,
    parameter int NUM_SS     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              i_PCLK,
    input  logic              i_PRESETn,
    input  logic              i_PSEL,
    input  logic              i_PENABLE,
    input  logic              i_PWRITE,
    input  logic [15:0]       i_PADDR,
    input  logic [DATA_W-1:0] i_PWDATA,
    input  logic [9:0]        i_BASE_ADDR,
    output logic [DATA_W-1:0] o_PRDATA,
    output logic              o_PREADY,
    output logic              o_PSLVERR,
    output logic              o_SCK,
    output logic              o_MOSI,
    input  logic              i_MISO,
    output logic [NUM_SS-1:0] o_SS
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = $clog2(2 * DATA_W);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, LOAD, HOLD} state_t;
    state_t state, state_nx;

    logic [5:0]        cfg;
    logic [2:0]        div_cnt;
    logic [EW-1:0]     edge_cnt;
    logic [DATA_W-1:0] tx_sh, rx_sh;
    logic              sck, mosi, lb, miso_in;
    logic              tx_ovf, rx_ovf;

    logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
    logic [AW-1:0]     tx_wr, tx_rd, rx_wr, rx_rd;
    logic [CW-1:0]     tx_cnt, rx_cnt;

    logic       cpol, cpha, busy, tick, load_word;
    logic       tx_full, tx_empty, rx_full, rx_empty;
    logic       hit, wr, rd, tx_push, rx_pop, rx_push, cfg_wr, cmd_wr, start, flush, sts_rd;
    logic [3:0] off;
    logic [1:0] ss_idx;
    logic [7:0] status;
    logic       unused_addr;

    assign cpol     = cfg[5];
    assign cpha     = cfg[4];
    assign ss_idx   = cfg[3:2] & 2'(NUM_SS - 1);
    assign busy     = (state != IDLE);
    // half-period of 2^code PCLK cycles
    assign tick     = (div_cnt == 3'((4'd1 << cfg[1:0]) - 4'd1));

    assign tx_full  = (tx_cnt == CW'(FIFO_DEPTH));
    assign tx_empty = (tx_cnt == '0);
    assign rx_full  = (rx_cnt == CW'(FIFO_DEPTH));
    assign rx_empty = (rx_cnt == '0);

    assign off      = i_PADDR[5:2];
    assign hit      = i_PRESETn && i_PSEL && i_PENABLE && (i_PADDR[15:6] == i_BASE_ADDR);
    assign wr       = hit && i_PWRITE;
    assign rd       = hit && !i_PWRITE;
    assign tx_push  = wr && (off == 4'h1) && !tx_full;
    assign rx_pop   = rd && (off == 4'h1) && !rx_empty;
    assign rx_push  = (state == LOAD) && !rx_full;
    assign cfg_wr   = wr && (off == 4'h0) && !busy;
    assign cmd_wr   = wr && (off == 4'h3);
    assign sts_rd   = rd && (off == 4'h0);
    assign start    = cmd_wr && i_PWDATA[1] && !busy && !tx_empty;
    assign flush    = cmd_wr && i_PWDATA[0] && !busy && !start;
    assign status   = {lb, tx_ovf, rx_ovf, rx_empty, rx_full, tx_empty, tx_full, busy};
    assign unused_addr = ^i_PADDR[1:0];

    always_comb begin
        o_PREADY  = hit;
        o_PRDATA  = '0;
        o_PSLVERR = 1'b0;
        if (rd && off == 4'h0) o_PRDATA = DATA_W'(status);
        if (rd && off == 4'h1) begin
            if (rx_empty) o_PSLVERR = 1'b1;
            else          o_PRDATA  = rx_mem[rx_rd];
        end
        if (wr && off == 4'h0) o_PSLVERR = busy;
        if (wr && off == 4'h1) o_PSLVERR = tx_full;
    end

    always_comb begin
        state_nx  = state;
        load_word = 1'b0;
        case (state)
            IDLE:  if (start) begin state_nx = SETUP; load_word = 1'b1; end
            SETUP: if (tick) state_nx = SHIFT;
            SHIFT: if (tick && edge_cnt == EW'(2 * DATA_W - 1)) state_nx = LOAD;
            LOAD:  if (!tx_empty) begin state_nx = SETUP; load_word = 1'b1; end
                   else state_nx = HOLD;
            HOLD:  if (tick) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_PCLK) begin
        if (!i_PRESETn) begin
            state    <= IDLE;
            cfg      <= '0;
            div_cnt  <= '0;
            edge_cnt <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            sck      <= 1'b0;
            mosi     <= 1'b0;
            tx_ovf   <= 1'b0;
            rx_ovf   <= 1'b0;
            tx_wr    <= '0;
            tx_rd    <= '0;
            tx_cnt   <= '0;
            rx_wr    <= '0;
            rx_rd    <= '0;
            rx_cnt   <= '0;
        end else begin
            state <= state_nx;
            if (cfg_wr) cfg <= i_PWDATA[5:0];
            if (state_nx != state || tick || state == IDLE || state == LOAD) div_cnt <= '0;
            else div_cnt <= div_cnt + 3'd1;
            if (state == IDLE) sck <= cpol;
            // CPHA=0 presents the MSB during SETUP; CPHA=1 drives it on the first edge
            if (load_word) begin
                edge_cnt <= '0;
                if (cpha) tx_sh <= tx_mem[tx_rd];
                else begin
                    mosi  <= tx_mem[tx_rd][DATA_W-1];
                    tx_sh <= tx_mem[tx_rd] << 1;
                end
            end
            if (state == SHIFT && tick) begin
                sck      <= ~sck;
                edge_cnt <= edge_cnt + EW'(1);
                if (edge_cnt[0] == cpha) rx_sh <= {rx_sh[DATA_W-2:0], miso_in};
                else begin
                    mosi  <= tx_sh[DATA_W-1];
                    tx_sh <= tx_sh << 1;
                end
            end
            // a new overflow wins over the clear-on-read
            if (sts_rd) begin
                tx_ovf <= 1'b0;
                rx_ovf <= 1'b0;
            end
            if (wr && off == 4'h1 && tx_full) tx_ovf <= 1'b1;
            if (state == LOAD && rx_full)     rx_ovf <= 1'b1;
            if (flush) begin
                tx_wr  <= '0;
                tx_rd  <= '0;
                tx_cnt <= '0;
                rx_wr  <= '0;
                rx_rd  <= '0;
                rx_cnt <= '0;
            end else begin
                if (tx_push)   tx_wr <= tx_wr + AW'(1);
                if (load_word) tx_rd <= tx_rd + AW'(1);
                if (rx_push)   rx_wr <= rx_wr + AW'(1);
                if (rx_pop)    rx_rd <= rx_rd + AW'(1);
                tx_cnt <= tx_cnt + CW'(tx_push) - CW'(load_word);
                rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
            end
        end
    end

    always_ff @(posedge i_PCLK) begin
        if (tx_push) tx_mem[tx_wr] <= i_PWDATA;
        if (rx_push) rx_mem[rx_wr] <= rx_sh;
    end

`ifdef APB_SPI_LOOPBACK_EN
    always_ff @(posedge i_PCLK) begin
        if (!i_PRESETn)          lb <= 1'b0;
        else if (cmd_wr && !busy) lb <= i_PWDATA[2];
    end
`else
    assign lb = 1'b0;
`endif
    assign miso_in = lb ? mosi : i_MISO;

    assign o_SCK  = sck;
    assign o_MOSI = mosi;

    always_comb begin
        o_SS = '1;
        for (int i = 0; i < NUM_SS; i++)
            if (busy && !lb && ss_idx == 2'(i)) o_SS[i] = 1'b0;
    end
endmodule

// File: tb/tb_apb_spi_master_fifo.sv
// Directed bench for apb_spi_master_fifo: APB vector table plus hand-written SPI burst sequences.
module tb_apb_spi_master_fifo;
    localparam time CLK_T = 10;

    logic        clk;
    logic        i_PRESETn, psel, penable, pwrite;
    logic [15:0] paddr;
    logic [7:0]  pwdata, o_PRDATA;
    logic        o_PREADY, o_PSLVERR, o_SCK, o_MOSI, i_MISO;
    logic [3:0]  o_SS;

    apb_spi_master_fifo dut (
        .i_PCLK(clk), .i_PRESETn(i_PRESETn), .i_PSEL(psel), .i_PENABLE(penable),
        .i_PWRITE(pwrite), .i_PADDR(paddr), .i_PWDATA(pwdata), .i_BASE_ADDR(10'd1),
        .o_PRDATA(o_PRDATA), .o_PREADY(o_PREADY), .o_PSLVERR(o_PSLVERR),
        .o_SCK(o_SCK), .o_MOSI(o_MOSI), .i_MISO(i_MISO), .o_SS(o_SS)
    );

    initial clk = 1'b0;
    always #(CLK_T / 2) clk = ~clk;

    // slave model: shifts a fixed stream out, advancing after each rising SCK while selected
    logic [63:0] slv_stream = 64'hC35AE71981422499;
    logic [5:0]  scnt = '0, sbase = '0, sidx;
    assign sidx   = scnt - sbase;
    assign i_MISO = slv_stream[6'd63 - sidx];

    int          sck_rise = 0, ss3_fall = 0, ss3_rise = 0, ss_fall = 0;
    logic [63:0] mosi_cap = '0;
    time         sck_last = 0, sck_per = 0;
    logic        ss_all;
    assign ss_all = &o_SS;

    always @(posedge o_SCK) begin
        if (o_SS != 4'hF) scnt <= scnt + 6'd1;
        sck_rise <= sck_rise + 1;
        mosi_cap <= {mosi_cap[62:0], o_MOSI};
        sck_per  <= $time - sck_last;
        sck_last <= $time;
    end
    always @(negedge o_SS[3]) ss3_fall <= ss3_fall + 1;
    always @(posedge o_SS[3]) ss3_rise <= ss3_rise + 1;
    always @(negedge ss_all)  ss_fall  <= ss_fall + 1;

    int pass_cnt = 0, total_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic apb(input logic wr, input logic [9:0] base, input logic [3:0] off,
                       input logic [7:0] wd, output logic rdy, output logic [7:0] rdat, output logic err);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = {base, off, 2'b00}; pwdata = wd;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        rdy = o_PREADY; rdat = o_PRDATA; err = o_PSLVERR;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic wr_chk(input string name, input logic [3:0] off, input logic [7:0] wd, input logic exp_err);
        logic r, e;
        logic [7:0] d;
        apb(1'b1, 10'd1, off, wd, r, d, e);
        chk({name, "_err"}, e, exp_err);
    endtask

    task automatic rd_chk(input string name, input logic [3:0] off, input logic [7:0] exp_d, input logic exp_err);
        logic r, e;
        logic [7:0] d;
        apb(1'b0, 10'd1, off, 8'h00, r, d, e);
        chk({name, "_data"}, d, exp_d);
        chk({name, "_err"}, e, exp_err);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (o_SS != 4'hF && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        total_cnt++;
        if (n < 3000) pass_cnt++;
        else $display("FAIL %s: still busy after %0d cycles, required idle", name, n);
    endtask

    typedef struct {
        logic       wr;
        logic [9:0] base;
        logic [3:0] off;
        logic [7:0] wd;
        logic       rdy;
        logic [7:0] rd;
        logic       err;
    } vec_t;
    localparam int NV = 15;
    vec_t tbl [NV];

    initial begin
        #(CLK_T * 50000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic rdy, err;
        logic [7:0] rdat;
        int r0, f0, g0, n;

        tbl[0]  = '{1'b0, 10'd1, 4'h0, 8'h00, 1'b1, 8'h14, 1'b0}; // reset STATUS
        tbl[1]  = '{1'b0, 10'd1, 4'h1, 8'h00, 1'b1, 8'h00, 1'b1}; // pop empty RX
        tbl[2]  = '{1'b1, 10'd1, 4'h1, 8'h11, 1'b1, 8'h00, 1'b0};
        tbl[3]  = '{1'b1, 10'd1, 4'h1, 8'h22, 1'b1, 8'h00, 1'b0};
        tbl[4]  = '{1'b1, 10'd1, 4'h1, 8'h33, 1'b1, 8'h00, 1'b0};
        tbl[5]  = '{1'b1, 10'd1, 4'h1, 8'h44, 1'b1, 8'h00, 1'b0};
        tbl[6]  = '{1'b1, 10'd1, 4'h1, 8'h55, 1'b1, 8'h00, 1'b1}; // push while full
        tbl[7]  = '{1'b0, 10'd1, 4'h0, 8'h00, 1'b1, 8'h52, 1'b0}; // tx_full, rx_empty, tx_ovf
        tbl[8]  = '{1'b0, 10'd1, 4'h0, 8'h00, 1'b1, 8'h12, 1'b0}; // tx_ovf cleared
        tbl[9]  = '{1'b1, 10'd2, 4'h3, 8'h01, 1'b0, 8'h00, 1'b0}; // address miss FLUSH
        tbl[10] = '{1'b0, 10'd1, 4'h0, 8'h00, 1'b1, 8'h12, 1'b0}; // still full
        tbl[11] = '{1'b1, 10'd1, 4'h3, 8'h01, 1'b1, 8'h00, 1'b0}; // FLUSH
        tbl[12] = '{1'b0, 10'd1, 4'h0, 8'h00, 1'b1, 8'h14, 1'b0};
        tbl[13] = '{1'b1, 10'd1, 4'h0, 8'h0D, 1'b1, 8'h00, 1'b0}; // CONFIG mode0 slave3 code01
        tbl[14] = '{1'b0, 10'd1, 4'h2, 8'h00, 1'b1, 8'h00, 1'b0}; // unmapped read

        i_PRESETn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ss", o_SS, 4'hF);
        chk("rst_sck", o_SCK, 1'b0);
        chk("rst_mosi", o_MOSI, 1'b0);
        chk("rst_pready", o_PREADY, 1'b0);
        chk("rst_prdata", o_PRDATA, 8'h00);
        chk("rst_pslverr", o_PSLVERR, 1'b0);
        i_PRESETn = 1'b1;

        for (int i = 0; i < NV; i++) begin
            apb(tbl[i].wr, tbl[i].base, tbl[i].off, tbl[i].wd, rdy, rdat, err);
            chk($sformatf("vec%0d_ready", i), rdy, tbl[i].rdy);
            chk($sformatf("vec%0d_err", i), err, tbl[i].err);
            if (!tbl[i].wr) chk($sformatf("vec%0d_rdata", i), rdat, tbl[i].rd);
        end

        // single byte, mode 0, PCLK/4 on SS[3]
        r0 = sck_rise; f0 = ss3_fall; g0 = ss3_rise; sbase = scnt;
        wr_chk("t1_push", 4'h1, 8'hA5, 1'b0);
        wr_chk("t1_start", 4'h3, 8'h02, 1'b0);
        chk("t1_ss_low", o_SS, 4'h7);
        rd_chk("t1_busy_status", 4'h0, 8'h15, 1'b0);
        wait_idle("t1_wait");
        chk("t1_sck_edges", sck_rise - r0, 8);
        chk("t1_mosi", mosi_cap[7:0], 8'hA5);
        chk("t1_sck_period", sck_per, 4 * CLK_T);
        chk("t1_ss_fall", ss3_fall - f0, 1);
        chk("t1_ss_rise", ss3_rise - g0, 1);
        rd_chk("t1_status", 4'h0, 8'h04, 1'b0);
        rd_chk("t1_pop", 4'h1, 8'hC3, 1'b0);

        // four-word burst with SS held, busy-time CONFIG and START
        r0 = sck_rise; f0 = ss3_fall; g0 = ss3_rise; sbase = scnt;
        wr_chk("t2_push0", 4'h1, 8'hFF, 1'b0);
        wr_chk("t2_push1", 4'h1, 8'h12, 1'b0);
        wr_chk("t2_push2", 4'h1, 8'h34, 1'b0);
        wr_chk("t2_push3", 4'h1, 8'h56, 1'b0);
        wr_chk("t2_start", 4'h3, 8'h02, 1'b0);
        wr_chk("t2_cfg_busy", 4'h0, 8'h00, 1'b1);
        wr_chk("t2_start_busy", 4'h3, 8'h02, 1'b0);
        wait_idle("t2_wait");
        chk("t2_sck_edges", sck_rise - r0, 32);
        chk("t2_mosi", mosi_cap[31:0], 32'hFF123456);
        chk("t2_ss_fall", ss3_fall - f0, 1);
        chk("t2_ss_rise", ss3_rise - g0, 1);
        rd_chk("t2_status", 4'h0, 8'h0C, 1'b0);
        rd_chk("t2_pop0", 4'h1, 8'hC3, 1'b0);
        rd_chk("t2_pop1", 4'h1, 8'h5A, 1'b0);
        rd_chk("t2_pop2", 4'h1, 8'hE7, 1'b0);
        rd_chk("t2_pop3", 4'h1, 8'h19, 1'b0);

        // five-word burst, RX overflows on the fifth
        r0 = sck_rise; sbase = scnt;
        for (int i = 1; i <= 4; i++) wr_chk($sformatf("t4_push%0d", i), 4'h1, 8'(i), 1'b0);
        wr_chk("t4_start", 4'h3, 8'h02, 1'b0);
        wr_chk("t4_push5", 4'h1, 8'h05, 1'b0);
        wait_idle("t4_wait");
        chk("t4_sck_edges", sck_rise - r0, 40);
        chk("t4_mosi", mosi_cap[39:0], 40'h0102030405);
        rd_chk("t4_status_ovf", 4'h0, 8'h2C, 1'b0);
        rd_chk("t4_status_clr", 4'h0, 8'h0C, 1'b0);
        rd_chk("t4_pop0", 4'h1, 8'hC3, 1'b0);
        rd_chk("t4_pop1", 4'h1, 8'h5A, 1'b0);
        rd_chk("t4_pop2", 4'h1, 8'hE7, 1'b0);
        rd_chk("t4_pop3", 4'h1, 8'h19, 1'b0);
        rd_chk("t4_pop_empty", 4'h1, 8'h00, 1'b1);

        // mode 3 (CPOL=1, CPHA=1), slave 3, PCLK/2
        wr_chk("m3_cfg", 4'h0, 8'h3C, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("m3_sck_idle", o_SCK, 1'b1);
        r0 = sck_rise; sbase = scnt;
        wr_chk("m3_push", 4'h1, 8'h96, 1'b0);
        wr_chk("m3_start", 4'h3, 8'h02, 1'b0);
        wait_idle("m3_wait");
        chk("m3_sck_edges", sck_rise - r0, 8);
        chk("m3_mosi", mosi_cap[7:0], 8'h96);
        chk("m3_sck_end", o_SCK, 1'b1);
        rd_chk("m3_pop", 4'h1, 8'hC3, 1'b0);

        // reset pulse in the middle of a burst
        wr_chk("t5_cfg", 4'h0, 8'h0D, 1'b0);
        repeat (3) @(posedge clk);
        r0 = sck_rise;
        wr_chk("t5_push0", 4'h1, 8'h77, 1'b0);
        wr_chk("t5_push1", 4'h1, 8'h88, 1'b0);
        wr_chk("t5_start", 4'h3, 8'h02, 1'b0);
        n = 0;
        while (sck_rise - r0 < 4 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t5_reached_bit4", (n < 500), 1'b1);
        @(posedge clk); #1;
        i_PRESETn = 1'b0;
        @(posedge clk); #1;
        chk("t5_ss", o_SS, 4'hF);
        chk("t5_sck", o_SCK, 1'b0);
        chk("t5_mosi", o_MOSI, 1'b0);
        i_PRESETn = 1'b1;
        rd_chk("t5_status", 4'h0, 8'h14, 1'b0);

        // CMD[2]: loopback in the option build, ignored otherwise (CONFIG now 0: slave 0)
        f0 = ss_fall; sbase = scnt;
        wr_chk("t6_push", 4'h1, 8'h3C, 1'b0);
        wr_chk("t6_cmd", 4'h3, 8'h06, 1'b0);
`ifdef APB_SPI_LOOPBACK_EN
        repeat (100) @(posedge clk);
        #1;
        chk("t6_ss_never_low", ss_fall - f0, 0);
        rd_chk("t6_status", 4'h0, 8'h84, 1'b0);
        rd_chk("t6_pop", 4'h1, 8'h3C, 1'b0);
`else
        wait_idle("t6_wait");
        chk("t6_ss_fall", ss_fall - f0, 1);
        rd_chk("t6_status", 4'h0, 8'h04, 1'b0);
        rd_chk("t6_pop", 4'h1, 8'hC3, 1'b0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
